// File: rtl/emu_pkg.sv
// Shared definitions for the emulation transactor: step FSM encoding,
// host read-map offsets (relative to OUT_BYTES) and step-count helpers.
package emu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2
    } step_state_t;

    localparam int CYC_CNT_OFFSET = 0;
    localparam int STATUS_OFFSET  = 4;

    localparam logic [8:0] STEP_COUNT_ZERO = 9'd256;

    // A host step count of zero requests the maximum run length.
    function automatic logic [8:0] step_count(input logic [7:0] din);
        return (din == 8'd0) ? STEP_COUNT_ZERO : {1'b0, din};
    endfunction

endpackage

// File: rtl/emu_step_fsm.sv
// Step sequencer: runs the DUT for N enabled cycles, then raises a one-cycle
// capture pulse before returning to idle.
module emu_step_fsm
    import emu_pkg::*;
(
    input  logic       clk_emu,
    input  logic       rst_emu,
    input  logic       start,
    input  logic [7:0] step_din,
    output logic       idle,
    output logic       dut_ce,
    output logic       busy,
    output logic       capture
);

    step_state_t state;
    logic [8:0]  remaining;

    assign idle = (state == ST_IDLE);

    // dut_ce drops on the same edge that counts the last enabled cycle, so the
    // capture cycle sees the DUT exactly N edges after the step began.
    always_ff @(posedge clk_emu or posedge rst_emu) begin
        if (rst_emu) begin
            state     <= ST_IDLE;
            remaining <= '0;
            dut_ce    <= 1'b0;
            busy      <= 1'b0;
            capture   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    capture <= 1'b0;
                    if (start) begin
                        state     <= ST_RUN;
                        remaining <= step_count(step_din);
                        dut_ce    <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_RUN: begin
                    remaining <= remaining - 9'd1;
                    if (remaining == 9'd1) begin
                        state   <= ST_CAPTURE;
                        dut_ce  <= 1'b0;
                        capture <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    capture <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    dut_ce  <= 1'b0;
                    busy    <= 1'b0;
                    capture <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/emu_transactor.sv
// Host-side transactor for an emulated DUT: stimulus buffering, output capture,
// cycle accounting and a registered host read port.
module emu_transactor
    import emu_pkg::*;
#(
    parameter int STIM_BYTES = 1,
    parameter int OUT_BYTES  = 3,
    parameter int ADDR_W     = 3
) (
    input  logic                    clk_emu,
    input  logic                    rst_emu,
    input  logic [7:0]              Din_emu,
    input  logic [ADDR_W-1:0]       Addr_emu,
    input  logic                    wr_emu,
    input  logic                    load_emu,
    input  logic                    get_emu,
    input  logic                    step_emu,
    output logic [7:0]              Dout_emu,
    output logic                    busy_emu,
    output logic [STIM_BYTES*8-1:0] stim_out,
    output logic                    dut_ce,
    input  logic [OUT_BYTES*8-1:0]  vect_in
);

    logic                   fsm_idle;
    logic                   capture;
    logic                   step_go;
    logic                   load_go;
    logic                   get_go;
    logic                   wr_go;
    int                     addr_idx;
    logic [7:0]             stim_buf [STIM_BYTES];
    logic [OUT_BYTES*8-1:0] vect_buf;
    logic [31:0]            cyc_cnt;
    logic                   ovf;
    logic [7:0]             rd_data;

    assign addr_idx = 32'(Addr_emu);

    // One command per cycle, highest priority wins, and nothing is accepted mid-step.
    assign step_go = fsm_idle & step_emu;
    assign load_go = fsm_idle & ~step_emu & load_emu;
    assign get_go  = fsm_idle & ~step_emu & ~load_emu & get_emu;
    assign wr_go   = fsm_idle & ~step_emu & ~load_emu & ~get_emu & wr_emu;

    emu_step_fsm u_step_fsm (
        .clk_emu  (clk_emu),
        .rst_emu  (rst_emu),
        .start    (step_go),
        .step_din (Din_emu),
        .idle     (fsm_idle),
        .dut_ce   (dut_ce),
        .busy     (busy_emu),
        .capture  (capture)
    );

    always_ff @(posedge clk_emu or posedge rst_emu) begin
        if (rst_emu) begin
            for (int k = 0; k < STIM_BYTES; k++) stim_buf[k] <= 8'h00;
            stim_out <= '0;
            vect_buf <= '0;
        end else begin
            for (int k = 0; k < STIM_BYTES; k++) begin
                if (wr_go && addr_idx == k) stim_buf[k] <= Din_emu;
                if (step_go || load_go) stim_out[8*k +: 8] <= stim_buf[k];
            end
            if (get_go || capture) vect_buf <= vect_in;
        end
    end

    // The overflow flag is sticky until reset so the host can spot a wrapped count.
    always_ff @(posedge clk_emu or posedge rst_emu) begin
        if (rst_emu) begin
            cyc_cnt <= '0;
            ovf     <= 1'b0;
        end else if (dut_ce) begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (cyc_cnt == 32'hFFFF_FFFF) ovf <= 1'b1;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        for (int k = 0; k < OUT_BYTES; k++) begin
            if (addr_idx == k) rd_data = vect_buf[8*k +: 8];
        end
        for (int k = 0; k < 4; k++) begin
            if (addr_idx == OUT_BYTES + CYC_CNT_OFFSET + k) rd_data = cyc_cnt[8*k +: 8];
        end
        if (addr_idx == OUT_BYTES + STATUS_OFFSET) rd_data = {busy_emu, 6'b0, ovf};
    end

    always_ff @(posedge clk_emu or posedge rst_emu) begin
        if (rst_emu) Dout_emu <= 8'h00;
        else         Dout_emu <= rd_data;
    end

endmodule

// File: tb/tb_emu_transactor.sv
// Scoreboard bench for emu_transactor driving a simple 8-bit counter as the emulated DUT.
module tb_emu_transactor;

    localparam int STIM_BYTES = 1;
    localparam int OUT_BYTES  = 3;
    localparam int ADDR_W     = 3;

    logic                    clk_emu = 1'b0;
    logic                    rst_emu = 1'b1;
    logic [7:0]              Din_emu = 8'h00;
    logic [ADDR_W-1:0]       Addr_emu = '0;
    logic                    wr_emu = 1'b0;
    logic                    load_emu = 1'b0;
    logic                    get_emu = 1'b0;
    logic                    step_emu = 1'b0;
    logic [7:0]              Dout_emu;
    logic                    busy_emu;
    logic [STIM_BYTES*8-1:0] stim_out;
    logic                    dut_ce;
    logic [OUT_BYTES*8-1:0]  vect_in;
    logic [7:0]              dut_cnt;

    typedef struct { string name; logic [7:0] exp; } rd_exp_t;
    typedef struct { string name; int ce; int busy; } step_exp_t;

    rd_exp_t   rd_q[$];
    step_exp_t step_q[$];
    int        vectors = 0;
    int        miscompares = 0;
    logic      rd_req = 1'b0;
    logic      rd_seen = 1'b0;

    always #5 clk_emu = ~clk_emu;

    emu_transactor #(.STIM_BYTES(STIM_BYTES), .OUT_BYTES(OUT_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk_emu  (clk_emu),
        .rst_emu  (rst_emu),
        .Din_emu  (Din_emu),
        .Addr_emu (Addr_emu),
        .wr_emu   (wr_emu),
        .load_emu (load_emu),
        .get_emu  (get_emu),
        .step_emu (step_emu),
        .Dout_emu (Dout_emu),
        .busy_emu (busy_emu),
        .stim_out (stim_out),
        .dut_ce   (dut_ce),
        .vect_in  (vect_in)
    );

    always @(posedge clk_emu or posedge rst_emu) begin
        if (rst_emu)     dut_cnt <= 8'h00;
        else if (dut_ce) dut_cnt <= dut_cnt + 8'd1;
    end
    assign vect_in = {8'hC3, ~dut_cnt, dut_cnt};

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Read-response monitor: Dout_emu is valid one edge after a read request.
    initial forever begin
        @(posedge clk_emu);
        rd_seen <= rd_req;
    end

    initial forever begin
        rd_exp_t e;
        @(negedge clk_emu);
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                check_output("rd_unexpected", 32'(Dout_emu), 32'hFFFF_FFFF);
            end else begin
                e = rd_q.pop_front();
                check_output(e.name, 32'(Dout_emu), 32'(e.exp));
            end
        end
    end

    // Step monitor: counts enabled and busy cycles, compares when busy falls.
    initial begin
        int        ce_cnt;
        int        busy_cnt;
        logic      busy_prev;
        step_exp_t s;
        ce_cnt = 0;
        busy_cnt = 0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk_emu);
            if (rst_emu) begin
                ce_cnt = 0;
                busy_cnt = 0;
                busy_prev = 1'b0;
            end else begin
                if (busy_emu) busy_cnt++;
                if (dut_ce)   ce_cnt++;
                if (busy_prev && !busy_emu) begin
                    if (step_q.size() == 0) begin
                        check_output("step_unexpected", 32'(busy_cnt), 32'hFFFF_FFFF);
                    end else begin
                        s = step_q.pop_front();
                        check_output({s.name, "_ce_cycles"}, 32'(ce_cnt), 32'(s.ce));
                        check_output({s.name, "_busy_cycles"}, 32'(busy_cnt), 32'(s.busy));
                    end
                    ce_cnt = 0;
                    busy_cnt = 0;
                end
                busy_prev = busy_emu;
            end
        end
    end

    task automatic apply_stimulus(input logic wr, input logic load, input logic get,
                                  input logic step, input int addr, input logic [7:0] din);
        @(negedge clk_emu);
        wr_emu   = wr;
        load_emu = load;
        get_emu  = get;
        step_emu = step;
        Addr_emu = ADDR_W'(addr);
        Din_emu  = din;
        @(negedge clk_emu);
        wr_emu   = 1'b0;
        load_emu = 1'b0;
        get_emu  = 1'b0;
        step_emu = 1'b0;
    endtask

    task automatic read_reg(input string name, input int addr, input logic [7:0] exp);
        @(negedge clk_emu);
        Addr_emu = ADDR_W'(addr);
        rd_req   = 1'b1;
        rd_q.push_back('{name, exp});
    endtask

    task automatic read_done();
        @(negedge clk_emu);
        rd_req = 1'b0;
    endtask

    task automatic start_step(input string name, input logic [7:0] din, input int ce, input int busy);
        step_q.push_back('{name, ce, busy});
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, din);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_emu && n < 1000) begin
            @(negedge clk_emu);
            n++;
        end
        check_output({name, "_done"}, 32'(busy_emu), 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk_emu);
        check_output("rst_dut_ce", 32'(dut_ce), 32'h0);
        check_output("rst_busy", 32'(busy_emu), 32'h0);
        check_output("rst_stim_out", 32'(stim_out), 32'h0);
        check_output("rst_dout", 32'(Dout_emu), 32'h0);
        rst_emu = 1'b0;

        // Write then load stimulus
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h35);
        check_output("wr_no_apply", 32'(stim_out), 32'h00);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00);
        check_output("load_stim_out", 32'(stim_out), 32'h35);
        check_output("load_dut_ce", 32'(dut_ce), 32'h0);

        // Get with counter at zero
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00);
        read_reg("get_b0", 0, 8'h00);
        read_reg("get_b1", 1, 8'hFF);
        read_reg("get_b2", 2, 8'hC3);
        read_done();

        // Step 5
        start_step("step5", 8'd5, 5, 6);
        wait_idle("step5");
        read_reg("step5_b0", 0, 8'h05);
        read_reg("step5_b1", 1, 8'hFA);
        read_reg("step5_cyc0", 3, 8'h05);
        read_reg("step5_cyc1", 4, 8'h00);
        read_reg("step5_status", 7, 8'h00);
        read_done();

        // Step 0 means 256 from a fresh reset
        @(negedge clk_emu);
        rst_emu = 1'b1;
        @(negedge clk_emu);
        rst_emu = 1'b0;
        start_step("step256", 8'd0, 256, 257);
        wait_idle("step256");
        read_reg("step256_b1", 1, 8'hFF);
        read_reg("step256_cyc0", 3, 8'h00);
        read_reg("step256_cyc1", 4, 8'h01);
        read_reg("step256_cyc2", 5, 8'h00);
        read_done();

        // Simultaneous strobes and strobes while busy
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 8'h11);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00);
        check_output("prio_setup", 32'(stim_out), 32'h11);
        step_q.push_back('{"prio_step", 6, 7});
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 0, 8'd6);
        check_output("prio_busy", 32'(busy_emu), 32'h1);
        check_output("prio_stim_out", 32'(stim_out), 32'h11);
        repeat (2) @(negedge clk_emu);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 0, 8'h99);
        read_reg("busy_get_ignored", 0, 8'h00);
        read_reg("busy_status", 7, 8'h80);
        read_done();
        wait_idle("prio_step");
        read_reg("prio_b0", 0, 8'h06);
        read_done();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h00);
        check_output("busy_wr_ignored", 32'(stim_out), 32'h11);

        // Reset in the middle of a long step
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 8'd200);
        repeat (50) @(negedge clk_emu);
        check_output("midrun_busy_before", 32'(busy_emu), 32'h1);
        #2 rst_emu = 1'b1;
        #1;
        check_output("midrun_dut_ce", 32'(dut_ce), 32'h0);
        check_output("midrun_busy", 32'(busy_emu), 32'h0);
        check_output("midrun_stim_out", 32'(stim_out), 32'h0);
        for (int a = 0; a < 8; a++) read_reg($sformatf("rst_rd%0d", a), a, 8'h00);
        read_done();
        rst_emu = 1'b0;
        for (int a = 0; a < 8; a++) read_reg($sformatf("post_rst_rd%0d", a), a, 8'h00);
        read_done();

        // Cycle counter wrap
        @(negedge clk_emu);
        force dut.cyc_cnt = 32'hFFFF_FFFE;
        #1 release dut.cyc_cnt;
        read_reg("wrap_preset0", 3, 8'hFE);
        read_reg("wrap_preset3", 6, 8'hFF);
        read_done();
        start_step("wrap_step", 8'd3, 3, 4);
        wait_idle("wrap_step");
        read_reg("wrap_b0", 0, 8'h03);
        read_reg("wrap_cyc0", 3, 8'h01);
        read_reg("wrap_cyc1", 4, 8'h00);
        read_reg("wrap_cyc3", 6, 8'h00);
        read_reg("wrap_status", 7, 8'h01);
        read_done();

        repeat (2) @(negedge clk_emu);
        check_output("rd_q_drained", 32'(rd_q.size()), 32'h0);
        check_output("step_q_drained", 32'(step_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
